// File: rtl/viterbi_pkg.sv
// Shared definitions for the convolutional-encoder / binary-symmetric-channel block.
// Holds the noise LFSR polynomial and step function, the channel FSM state type
// and the default code (K=5, rate 1/2, generators 11111 / 11011).
package viterbi_pkg;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  localparam int DEF_K = 5;
  localparam int DEF_N = 2;
  // Generator j occupies bits [j*K +: K]; bit t of a generator taps the input bit t steps back.
  localparam logic [DEF_N*DEF_K-1:0] DEF_G_VEC = {5'b11111, 5'b11011};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } chan_state_e;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/bsc_lfsr.sv
// Noise source: 32-bit Galois LFSR plus per-bit threshold compare giving N flip decisions.
// Latency: flip is combinational from the current LFSR state; state advances N steps on step.
// Backpressure: none internally; the caller only pulses step when a symbol is produced.
// Ports: clk, rst_n (async low, state=1), load/seed (seed 0 is replaced by 1),
//        step (advance N steps), thresh (flip when draw < thresh), flip[N-1:0].
module bsc_lfsr
  import viterbi_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [31:0]   seed,
  input  logic          step,
  input  logic [15:0]   thresh,
  output logic [N-1:0]  flip
);

  logic [31:0] lfsr_q, lfsr_d;

  // Draw j is the low half-word after step j+1 from the current state.
  always_comb begin
    lfsr_d = lfsr_q;
    flip   = '0;
    for (int j = 0; j < N; j++) begin
      lfsr_d  = lfsr_step(lfsr_d);
      flip[j] = (lfsr_d[15:0] < thresh);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 32'd1;
    end else if (load) begin
      lfsr_q <= (seed == 32'd0) ? 32'd1 : seed;
    end else if (step) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/conv_bsc_channel.sv
// Rate-1/N convolutional encoder feeding a binary symmetric channel (noisy + clean symbols).
// Latency: 1 cycle from accepted bit to registered symbol on out_*; one-entry output register.
// Backpressure: in_ready drops while the output register is full and out_ready is low; LFSR holds.
// Ports: clk, rst_n (async low); start (frame restart, loads cfg_seed); cfg_thresh (flip prob/65536);
//        in_valid/in_ready/in_bit/in_last data stream; out_valid/out_ready/out_sym/out_clean/out_last
//        symbol stream; busy; err_count (flipped bits) and sym_count (delivered symbols), saturating.
// Option: define CONV_TAIL_EN to flush K-1 zero tail bits after in_last (out_last on final tail symbol).
module conv_bsc_channel
  import viterbi_pkg::*;
#(
  parameter int K = DEF_K,
  parameter int N = DEF_N,
  parameter logic [N*K-1:0] G_VEC = DEF_G_VEC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [31:0]   cfg_seed,
  input  logic [15:0]   cfg_thresh,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_bit,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_sym,
  output logic [N-1:0]  out_clean,
  output logic          out_last,
  output logic          busy,
  output logic [15:0]   err_count,
  output logic [15:0]   sym_count
);

  chan_state_e   state_q;
  logic [K-2:0]  enc_q, enc_d;
  logic          out_valid_q, out_last_q;
  logic [N-1:0]  out_sym_q, out_clean_q;
  logic [15:0]   err_q, sym_q, err_d, sym_d;

  logic          out_free, out_hs, in_fire, tail_fire, produce, enc_bit, last_d;
  logic [K-1:0]  r;
  logic [N-1:0]  clean_d, flip, diff;
  logic [2:0]    nflip;
  logic [16:0]   err_sum;

`ifdef CONV_TAIL_EN
  localparam int TAIL_LEN = K - 1;
  logic [3:0]    tail_cnt_q;
`endif

  // The output register can take a new symbol when empty or draining this cycle.
  assign out_free = !out_valid_q || out_ready;
  assign out_hs   = out_valid_q && out_ready;
  assign in_ready = (state_q == RUN) && !start && out_free;
  assign in_fire  = in_valid && in_ready;

`ifdef CONV_TAIL_EN
  assign tail_fire = (state_q == TAIL) && !start && out_free && (tail_cnt_q != 4'(TAIL_LEN));
  assign last_d    = tail_fire && (tail_cnt_q == 4'(TAIL_LEN - 1));
`else
  assign tail_fire = 1'b0;
  assign last_d    = in_fire && in_last;
`endif

  assign produce = in_fire || tail_fire;
  // Tail symbols shift zeros through the encoder.
  assign enc_bit = in_fire ? in_bit : 1'b0;
  assign r       = {enc_q, enc_bit};
  assign enc_d   = {enc_q[K-3:0], enc_bit};

  always_comb begin
    clean_d = '0;
    for (int j = 0; j < N; j++) begin
      clean_d[j] = ^(r & G_VEC[j*K +: K]);
    end
  end

  bsc_lfsr #(.N(N)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start),
    .seed   (cfg_seed),
    .step   (produce),
    .thresh (cfg_thresh),
    .flip   (flip)
  );

  // Flips in the symbol being handed over are counted at handshake time.
  assign diff = out_sym_q ^ out_clean_q;
  always_comb begin
    nflip = '0;
    for (int j = 0; j < N; j++) begin
      nflip = nflip + {2'b00, diff[j]};
    end
  end

  assign err_sum = {1'b0, err_q} + 17'(nflip);
  assign err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  assign sym_d   = (sym_q == 16'hFFFF) ? sym_q : sym_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      enc_q       <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      out_clean_q <= '0;
      out_last_q  <= 1'b0;
      err_q       <= '0;
      sym_q       <= '0;
`ifdef CONV_TAIL_EN
      tail_cnt_q  <= '0;
`endif
    end else if (start) begin
      // Restart wins over any pending handshake: the frame begins from a clean slate.
      state_q     <= RUN;
      enc_q       <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      out_clean_q <= '0;
      out_last_q  <= 1'b0;
      err_q       <= '0;
      sym_q       <= '0;
`ifdef CONV_TAIL_EN
      tail_cnt_q  <= '0;
`endif
    end else begin
      if (out_hs) begin
        err_q <= err_d;
        sym_q <= sym_d;
      end

      if (produce) begin
        out_valid_q <= 1'b1;
        out_sym_q   <= clean_d ^ flip;
        out_clean_q <= clean_d;
        out_last_q  <= last_d;
        enc_q       <= enc_d;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        RUN: begin
          if (in_fire && in_last) begin
`ifdef CONV_TAIL_EN
            state_q <= TAIL;
`else
            state_q <= DONE;
`endif
          end
        end
`ifdef CONV_TAIL_EN
        TAIL: begin
          if (tail_fire) tail_cnt_q <= tail_cnt_q + 4'd1;
          // Leave TAIL only once the flagged final symbol has been taken downstream.
          if (out_hs && out_last_q) state_q <= DONE;
        end
`endif
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_clean = out_clean_q;
  assign out_last  = out_last_q;
  assign err_count = err_q;
  assign sym_count = sym_q;
  assign busy      = (state_q == RUN) || (state_q == TAIL) || out_valid_q;

endmodule

// File: tb/tb_conv_bsc_channel.sv
// Bench for conv_bsc_channel: default-code instance plus a K=3 {111,101} instance on shared inputs,
// randomized traffic compared against a convolution + LFSR reference model.
module tb_conv_bsc_channel;

  localparam int K5 = 5;
`ifdef CONV_TAIL_EN
  localparam int TAILN = K5 - 1;
`else
  localparam int TAILN = 0;
`endif
  localparam logic [9:0]  G5   = {5'b11111, 5'b11011};
  localparam logic [31:0] POLY = 32'h8020_0003;

  typedef struct packed {
    logic [1:0] sym;
    logic [1:0] clean;
    logic       last;
  } sym_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_seed = '0;
  logic [15:0] cfg_thresh = '0;
  logic        in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b0;

  logic        in_ready, out_valid, out_last, busy;
  logic [1:0]  out_sym, out_clean;
  logic [15:0] err_count, sym_count;

  logic        s_in_ready, s_out_valid, s_out_last, s_busy;
  logic [1:0]  s_out_sym, s_out_clean;
  logic [15:0] s_err_count, s_sym_count;

  int   n_chk = 0;
  int   n_fail = 0;
  bit   tx_bits[$];
  sym_t rx_q[$], rx3_q[$], exp_q[$];
  int   exp_err;
  bit   stall_done;

  always #5 clk = ~clk;

  conv_bsc_channel dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_seed(cfg_seed), .cfg_thresh(cfg_thresh),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym), .out_clean(out_clean),
    .out_last(out_last), .busy(busy), .err_count(err_count), .sym_count(sym_count)
  );

  conv_bsc_channel #(.K(3), .N(2), .G_VEC(6'b111_101)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_seed(cfg_seed), .cfg_thresh(cfg_thresh),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_bit(in_bit), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_sym(s_out_sym), .out_clean(s_out_clean),
    .out_last(s_out_last), .busy(s_busy), .err_count(s_err_count), .sym_count(s_sym_count)
  );

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // Reference: each output bit is the GF(2) convolution of the bit history with its generator,
  // noise drawn from the LFSR sequence two draws per symbol.
  task automatic build_model(input logic [31:0] seed, input logic [15:0] th);
    bit          seq[$];
    logic [31:0] s;
    logic [9:0]  g;
    sym_t        e;
    seq = tx_bits;
    for (int t = 0; t < TAILN; t++) seq.push_back(1'b0);
    g = G5;
    s = (seed == 32'd0) ? 32'd1 : seed;
    exp_q.delete();
    exp_err = 0;
    for (int i = 0; i < seq.size(); i++) begin
      e = '0;
      for (int j = 0; j < 2; j++) begin
        for (int t = 0; t < K5; t++)
          if (i - t >= 0 && g[j*K5 + t]) e.clean[j] = e.clean[j] ^ seq[i-t];
        s = lfsr_next(s);
        e.sym[j] = e.clean[j] ^ (s[15:0] < th);
        if (s[15:0] < th) exp_err++;
      end
      e.last = (i == seq.size() - 1);
      exp_q.push_back(e);
    end
  endtask

  function automatic int count_mis(input sym_t a[$], input sym_t b[$]);
    int m;
    m = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++)
      if (a[i] !== b[i]) m++;
    return m;
  endfunction

  task automatic do_start(input logic [31:0] seed, input logic [15:0] th);
    @(posedge clk); #1;
    cfg_seed = seed; cfg_thresh = th; start = 1'b1;
    in_valid = 1'b1; in_bit = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL start_no_accept: in_ready=%b required 0", in_ready);
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
  endtask

  // Drives tx_bits with random gaps, collects handshaken symbols of both instances.
  task automatic run_frame(input int ready_pct, input int stall_at);
    int   idx, cyc, stall_left;
    bit   stalling, got_last;
    logic [4:0] snap;
    rx_q.delete(); rx3_q.delete();
    idx = 0; cyc = 0; stall_left = 5; got_last = 0; stall_done = 0; snap = '0;
    while (!got_last && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      stalling = 0;
      if (stall_at >= 0 && stall_left > 0 && out_valid && rx_q.size() >= stall_at) begin
        if (stall_left == 5) snap = {out_sym, out_clean, out_last};
        out_ready = 1'b0; stalling = 1; stall_left--;
        if (stall_left == 0) stall_done = 1;
      end else begin
        out_ready = ($urandom_range(0, 99) < ready_pct);
      end
      in_valid = (idx < tx_bits.size()) && ($urandom_range(0, 99) < 80);
      in_bit   = (idx < tx_bits.size()) ? tx_bits[idx] : 1'b0;
      in_last  = (idx == tx_bits.size() - 1);
      @(negedge clk);
      if (stalling) begin
        n_chk++;
        if ({out_valid, out_sym, out_clean, out_last, in_ready} !== {1'b1, snap, 1'b0}) begin
          n_fail++;
          $display("FAIL stall_hold: v/sym/clean/last/in_ready=%b/%b/%b/%b/%b required 1/%b/%b/%b/0",
                   out_valid, out_sym, out_clean, out_last, in_ready, snap[4:3], snap[2:1], snap[0]);
        end
      end
      if (in_valid && in_ready) idx++;
      if (s_out_valid && out_ready) rx3_q.push_back({s_out_sym, s_out_clean, s_out_last});
      if (out_valid && out_ready) begin
        rx_q.push_back({out_sym, out_clean, out_last});
        if (out_last) got_last = 1;
      end
    end
    if (!got_last) begin
      n_chk++; n_fail++;
      $display("FAIL frame_timeout: out_last not seen after %0d cycles, %0d symbols", cyc, rx_q.size());
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: %b required 0", out_valid); end
    n_chk++; if (out_sym !== 2'b00) begin n_fail++; $display("FAIL rst_out_sym: %b required 00", out_sym); end
    n_chk++; if (out_clean !== 2'b00) begin n_fail++; $display("FAIL rst_out_clean: %b required 00", out_clean); end
    n_chk++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: %b required 0", out_last); end
    n_chk++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL rst_err_count: %0d required 0", err_count); end
    n_chk++; if (sym_count !== 16'd0) begin n_fail++; $display("FAIL rst_sym_count: %0d required 0", sym_count); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: %b required 0", busy); end
    @(posedge clk); #1; rst_n = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({in_ready, busy, s_in_ready, s_busy, s_out_valid, s_sym_count} !== 21'd0) begin
      n_fail++;
      $display("FAIL idle_state: in_ready=%b busy=%b k3 in_ready=%b busy=%b valid=%b syms=%0d required all 0",
               in_ready, busy, s_in_ready, s_busy, s_out_valid, s_sym_count);
    end
    @(posedge clk); #1; in_valid = 1'b0;
  endtask

  task automatic test_k3_vector();
    logic [1:0] k3_exp [4];
    int m;
    k3_exp[0] = 2'b11; k3_exp[1] = 2'b10; k3_exp[2] = 2'b00; k3_exp[3] = 2'b01;
    tx_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_start(32'hDEAD_BEEF, 16'h0000);
    build_model(32'hDEAD_BEEF, 16'h0000);
    run_frame(100, -1);
    n_chk++;
    if (rx3_q.size() != 4 + (TAILN > 0 ? 2 : 0)) begin
      n_fail++; $display("FAIL k3_count: %0d symbols required %0d", rx3_q.size(), 4 + (TAILN > 0 ? 2 : 0));
    end
    for (int i = 0; i < 4 && i < rx3_q.size(); i++) begin
      n_chk++;
      if (rx3_q[i].clean !== k3_exp[i]) begin
        n_fail++; $display("FAIL k3_clean[%0d]: %b required %b", i, rx3_q[i].clean, k3_exp[i]);
      end
      n_chk++;
      if (rx3_q[i].sym !== k3_exp[i]) begin
        n_fail++; $display("FAIL k3_sym[%0d]: %b required %b", i, rx3_q[i].sym, k3_exp[i]);
      end
    end
    n_chk++; if (s_err_count !== 16'd0) begin n_fail++; $display("FAIL k3_err_count: %0d required 0", s_err_count); end
    m = count_mis(rx_q, exp_q);
    n_chk++; if (m != 0) begin n_fail++; $display("FAIL k5_zero_thresh_stream: %0d mismatches required 0", m); end
    n_chk++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL k5_zero_thresh_err: %0d required 0", err_count); end
  endtask

  task automatic test_noise();
    int m, obs;
    tx_bits.delete();
    for (int i = 0; i < 1000 - TAILN; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
    do_start(32'hACE1_2024, 16'h8000);
    build_model(32'hACE1_2024, 16'h8000);
    run_frame(70, -1);
    m = count_mis(rx_q, exp_q);
    n_chk++; if (m != 0) begin n_fail++; $display("FAIL noise_stream: %0d mismatches required 0", m); end
    obs = 0;
    foreach (rx_q[i]) obs += (rx_q[i].sym[0] ^ rx_q[i].clean[0]) + (rx_q[i].sym[1] ^ rx_q[i].clean[1]);
    n_chk++; if (err_count !== 16'(obs)) begin n_fail++; $display("FAIL noise_err_vs_stream: %0d required %0d", err_count, obs); end
    n_chk++; if (err_count !== 16'(exp_err)) begin n_fail++; $display("FAIL noise_err_vs_model: %0d required %0d", err_count, exp_err); end
    n_chk++;
    if (err_count < 16'd900 || err_count > 16'd1100) begin
      n_fail++; $display("FAIL noise_err_range: %0d required 900..1100", err_count);
    end
    n_chk++; if (sym_count !== 16'd1000) begin n_fail++; $display("FAIL noise_sym_count: %0d required 1000", sym_count); end
  endtask

  task automatic test_stall();
    int m;
    tx_bits.delete();
    for (int i = 0; i < 40; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
    do_start(32'h0BAD_F00D, 16'h4000);
    build_model(32'h0BAD_F00D, 16'h4000);
    run_frame(100, 10);
    n_chk++; if (stall_done !== 1'b1) begin n_fail++; $display("FAIL stall_reached: %b required 1", stall_done); end
    m = count_mis(rx_q, exp_q);
    n_chk++; if (m != 0) begin n_fail++; $display("FAIL stall_stream: %0d mismatches required 0", m); end
    n_chk++; if (err_count !== 16'(exp_err)) begin n_fail++; $display("FAIL stall_err: %0d required %0d", err_count, exp_err); end
  endtask

  task automatic test_frame_len();
    int m, nlast;
    tx_bits.delete();
    for (int i = 0; i < 8; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
    do_start(32'd0, 16'h2800);
    build_model(32'd0, 16'h2800);
    run_frame(60, -1);
    n_chk++; if (rx_q.size() != 8 + TAILN) begin n_fail++; $display("FAIL frame_len: %0d symbols required %0d", rx_q.size(), 8 + TAILN); end
    nlast = 0;
    foreach (rx_q[i]) nlast += rx_q[i].last;
    n_chk++;
    if (nlast != 1 || rx_q.size() == 0 || rx_q[rx_q.size()-1].last !== 1'b1) begin
      n_fail++; $display("FAIL frame_last: %0d last flags required exactly 1 on final symbol", nlast);
    end
    m = count_mis(rx_q, exp_q);
    n_chk++; if (m != 0) begin n_fail++; $display("FAIL frame_stream: %0d mismatches required 0", m); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_done_busy: %b required 0", busy); end
  endtask

  task automatic test_reset_midframe();
    int m;
    do_start(32'h1234_5678, 16'h2000);
    @(posedge clk); #1; in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL inflight_before_reset: out_valid=%b required 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, out_sym, out_clean, out_last, busy, in_ready} !== 7'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: v=%b sym=%b clean=%b last=%b busy=%b in_ready=%b required all 0",
               out_valid, out_sym, out_clean, out_last, busy, in_ready);
    end
    n_chk++;
    if ({err_count, sym_count} !== 32'd0) begin
      n_fail++; $display("FAIL midreset_counts: err=%0d sym=%0d required 0/0", err_count, sym_count);
    end
    @(posedge clk); #1; in_valid = 1'b0; rst_n = 1'b1;
    tx_bits.delete();
    for (int i = 0; i < 6; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
    do_start(32'h5EED_0001, 16'h6000);
    build_model(32'h5EED_0001, 16'h6000);
    run_frame(100, -1);
    n_chk++;
    if (rx_q.size() == 0 || rx_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL midreset_first_symbol: got %0d symbols, first=%b required %b", rx_q.size(),
                         rx_q.size() ? rx_q[0] : 5'b0, exp_q[0]);
    end
    m = count_mis(rx_q, exp_q);
    n_chk++; if (m != 0) begin n_fail++; $display("FAIL midreset_stream: %0d mismatches required 0", m); end
  endtask

  task automatic test_repeat();
    logic [7:0]  pat;
    sym_t        rx1[$];
    logic [15:0] err1;
    int          m;
    pat = 8'b10110100;
    tx_bits.delete();
    for (int r = 0; r < 8; r++)
      for (int b = 0; b < 8; b++) tx_bits.push_back(pat[7-b]);
    do_start(32'hC0FF_EE11, 16'h3000);
    build_model(32'hC0FF_EE11, 16'h3000);
    run_frame(50, -1);
    rx1 = rx_q; err1 = err_count;
    m = count_mis(rx1, exp_q);
    n_chk++; if (m != 0) begin n_fail++; $display("FAIL repeat_run1_model: %0d mismatches required 0", m); end
    do_start(32'hC0FF_EE11, 16'h3000);
    run_frame(85, -1);
    m = count_mis(rx_q, rx1);
    n_chk++; if (m != 0) begin n_fail++; $display("FAIL repeat_identical: %0d differences required 0", m); end
    n_chk++; if (err_count !== err1) begin n_fail++; $display("FAIL repeat_err: %0d required %0d", err_count, err1); end
    n_chk++; if (sym_count !== 16'(64 + TAILN)) begin n_fail++; $display("FAIL repeat_sym_count: %0d required %0d", sym_count, 64 + TAILN); end
  endtask

  initial begin
    test_reset();
    test_k3_vector();
    test_noise();
    test_stall();
    test_frame_len();
    test_reset_midframe();
    test_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
